// File: rtl/code_tx_uart.sv
`default_nettype none
// ============================================================================
//  Module      : code_tx_uart
//  Description : Captures an 80-bit result word on the flag strobe and sends
//                its bytes MSB-first over an 8N1 UART line. Zero bytes can be
//                skipped, and a CR/LF terminator can be appended.
//  Revision    : 1.0  initial release
// ============================================================================
module code_tx_uart #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int CODE_W    = 80,
  parameter int SKIP_ZERO = 1,
  parameter int TERM_EN   = 1
) (
  input  logic              msclk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code_out,
  input  logic              flag,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int NB  = CODE_W / 8;
  localparam int NS  = NB + ((TERM_EN != 0) ? 2 : 0);
  localparam int IW  = (NS > 1) ? $clog2(NS) : 1;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] buf_q, buf_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;

  logic [7:0]        w_slot_byte [NS];
  logic [NS-1:0]     w_slot_vld;
  logic              w_nxt_found;
  logic [IW-1:0]     w_nxt_idx;
  logic [7:0]        w_cur_byte;

  // Code slots: slot 0 is the most significant byte of the captured word.
  for (genvar k = 0; k < NB; k++) begin : g_code_slot
    assign w_slot_byte[k] = buf_q[CODE_W-1-8*k -: 8];
    assign w_slot_vld[k]  = (SKIP_ZERO == 0) || (buf_q[CODE_W-1-8*k -: 8] != 8'h00);
  end

  // Terminator slots are always sent when enabled.
  if (TERM_EN != 0) begin : g_term
    assign w_slot_byte[NB]   = 8'h0D;
    assign w_slot_byte[NB+1] = 8'h0A;
    assign w_slot_vld[NB]    = 1'b1;
    assign w_slot_vld[NB+1]  = 1'b1;
  end

  // Lowest valid slot: from slot 0 when starting a message, else above idx.
  always_comb begin
    w_nxt_found = 1'b0;
    w_nxt_idx   = '0;
    for (int s = NS - 1; s >= 0; s--) begin
      if (w_slot_vld[s] && ((state_q == S_IDLE) || (s > int'(idx_q)))) begin
        w_nxt_found = 1'b1;
        w_nxt_idx   = IW'(s);
      end
    end
  end

  // Next-state logic; IDLE with busy set is the slot-search cycle after capture.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovr_d   = flag & busy_q;
    case (state_q)
      S_IDLE: begin
        if (!busy_q) begin
          if (flag) begin
            buf_d  = code_out;
            busy_d = 1'b1;
          end
        end else begin
          cnt_d = '0;
          bit_d = '0;
          if (w_nxt_found) begin
            state_d = S_START;
            idx_d   = w_nxt_idx;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          if (w_nxt_found) begin
            state_d = S_START;
            idx_d   = w_nxt_idx;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Byte of the slot being entered, used to pre-compute the registered line.
  always_comb begin
    w_cur_byte = 8'h00;
    for (int s = 0; s < NS; s++) begin
      if (idx_d == IW'(s)) begin
        w_cur_byte = w_slot_byte[s];
      end
    end
  end

  // Line level for the next state, so tx is a glitch-free register output.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = w_cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge msclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_code_tx_uart.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_code_tx_uart
//  Description : Directed self-checking bench for code_tx_uart (DIV = 10).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_code_tx_uart;

  localparam int DIV   = 10;
  localparam int FRAME = 10 * DIV;
  localparam int RMAX  = 1300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [79:0] code;
  logic        flag_r;
  int          sel;
  int          tests;
  int          fails;

  logic flag0, flag1, flag2;
  logic tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2, ovr0, ovr1, ovr2;
  logic tx_s, busy_s, done_s, ovr_s;

  logic       rec_tx   [0:RMAX-1];
  logic       rec_busy [0:RMAX-1];
  logic       rec_done [0:RMAX-1];
  logic       rec_ovr  [0:RMAX-1];
  logic [7:0] exp_b    [0:15];
  int         exp_n;

  assign flag0 = flag_r && (sel == 0);
  assign flag1 = flag_r && (sel == 1);
  assign flag2 = flag_r && (sel == 2);

  code_tx_uart #(.CLK_HZ(1000), .BAUD(100), .CODE_W(80), .SKIP_ZERO(1), .TERM_EN(1)) u_skip (
    .msclk(clk), .rst_n(rst_n), .code_out(code), .flag(flag0),
    .tx(tx0), .busy(busy0), .done(done0), .overrun(ovr0));
  code_tx_uart #(.CLK_HZ(1000), .BAUD(100), .CODE_W(80), .SKIP_ZERO(0), .TERM_EN(1)) u_all (
    .msclk(clk), .rst_n(rst_n), .code_out(code), .flag(flag1),
    .tx(tx1), .busy(busy1), .done(done1), .overrun(ovr1));
  code_tx_uart #(.CLK_HZ(1000), .BAUD(100), .CODE_W(80), .SKIP_ZERO(1), .TERM_EN(0)) u_noterm (
    .msclk(clk), .rst_n(rst_n), .code_out(code), .flag(flag2),
    .tx(tx2), .busy(busy2), .done(done2), .overrun(ovr2));

  always_comb begin
    case (sel)
      1:       begin tx_s = tx1; busy_s = busy1; done_s = done1; ovr_s = ovr1; end
      2:       begin tx_s = tx2; busy_s = busy2; done_s = done2; ovr_s = ovr2; end
      default: begin tx_s = tx0; busy_s = busy0; done_s = done0; ovr_s = ovr0; end
    endcase
  end

  // Expected line level k cycles after the capture edge for bytes exp_b[0..exp_n-1].
  function automatic logic exp_line(input int k);
    int rel, f, b;
    if (k < 1 || k >= 1 + FRAME * exp_n) return 1'b1;
    rel = k - 1;
    f   = rel / FRAME;
    b   = (rel % FRAME) / DIV;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return exp_b[f][b-1];
  endfunction

  // Select an instance and present a one-cycle flag on the next edge.
  task automatic launch(input int inst, input logic [79:0] c);
    @(negedge clk);
    sel    = inst;
    code   = c;
    flag_r = 1'b1;
  endtask

  // Record outputs at negedges; index k is k cycles after the capture edge.
  task automatic record(input int n, input int f2_k, input logic [79:0] f2_code);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rec_tx[k]   = tx_s;
      rec_busy[k] = busy_s;
      rec_done[k] = done_s;
      rec_ovr[k]  = ovr_s;
      flag_r      = (k == f2_k);
      if (k == f2_k) code = f2_code;
    end
    flag_r = 1'b0;
  endtask

  task automatic test_reset;
    logic [11:0] obs;
    logic [10:0] st;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    obs = {tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2, ovr0, ovr1, ovr2};
    tests++;
    if (obs !== 12'b111_000_000_000) begin
      fails++; $display("FAIL reset_state got=%b exp=%b", obs, 12'b111_000_000_000);
    end
    rst_n = 1'b1;
    launch(1, 80'h3C57454C434F4D453C3B);
    record(150, -1, 80'h0);
    tests++;
    if ({rec_tx[149], rec_busy[149]} !== 2'b01) begin
      fails++; $display("FAIL reset_pre_data got tx,busy=%b exp=01", {rec_tx[149], rec_busy[149]});
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({tx1, busy1, done1, ovr1} !== 4'b1000) begin
      fails++; $display("FAIL reset_mid_data got tx,busy,done,ovr=%b exp=1000", {tx1, busy1, done1, ovr1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    launch(1, 80'h3C57454C434F4D453C3B);
    record(1205, -1, 80'h0);
    for (int j = 0; j < 11; j++) st[j] = rec_tx[j];
    tests++;
    if (st !== 11'b000_0000_0001) begin
      fails++; $display("FAIL reset_clean_start got=%b exp=%b", st, 11'b000_0000_0001);
    end
    tests++;
    if ({rec_busy[1201], rec_done[1201], rec_busy[1202], rec_done[1202]} !== 4'b1001) begin
      fails++; $display("FAIL reset_clean_done got=%b exp=1001",
                        {rec_busy[1201], rec_done[1201], rec_busy[1202], rec_done[1202]});
    end
  endtask

  task automatic test_skip_zero;
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h0D; exp_b[3] = 8'h0A; exp_n = 4;
    launch(0, 80'h00000000000000004142);
    record(425, -1, 80'h0);
    tests++;
    if (rec_tx[0] !== 1'b1) begin
      fails++; $display("FAIL skip_latency tx@0 got=%b exp=1", rec_tx[0]);
    end
    for (int p = 0; p < exp_n * 10 + 1; p++) begin
      logic [9:0] obs, want;
      for (int j = 0; j < 10; j++) begin
        obs[j]  = rec_tx[1 + p * 10 + j];
        want[j] = exp_line(1 + p * 10 + j);
      end
      tests++;
      if (obs !== want) begin
        fails++; $display("FAIL skip_bit%0d got=%b exp=%b", p, obs, want);
      end
    end
    tests++;
    if ({rec_busy[401], rec_done[401], rec_busy[402], rec_done[402], rec_done[403]} !== 5'b10010) begin
      fails++; $display("FAIL skip_done_timing got=%b exp=10010",
                        {rec_busy[401], rec_done[401], rec_busy[402], rec_done[402], rec_done[403]});
    end
  endtask

  task automatic test_no_skip;
    exp_b[0] = 8'h3C; exp_b[1] = 8'h57; exp_b[2]  = 8'h45; exp_b[3]  = 8'h4C;
    exp_b[4] = 8'h43; exp_b[5] = 8'h4F; exp_b[6]  = 8'h4D; exp_b[7]  = 8'h45;
    exp_b[8] = 8'h3C; exp_b[9] = 8'h3B; exp_b[10] = 8'h0D; exp_b[11] = 8'h0A;
    exp_n = 12;
    launch(1, 80'h3C57454C434F4D453C3B);
    record(1215, -1, 80'h0);
    for (int p = 0; p < exp_n * 10 + 1; p++) begin
      logic [9:0] obs, want;
      for (int j = 0; j < 10; j++) begin
        obs[j]  = rec_tx[1 + p * 10 + j];
        want[j] = exp_line(1 + p * 10 + j);
      end
      tests++;
      if (obs !== want) begin
        fails++; $display("FAIL noskip_bit%0d got=%b exp=%b", p, obs, want);
      end
    end
    tests++;
    if ({rec_done[1201], rec_done[1202], rec_busy[1202]} !== 3'b010) begin
      fails++; $display("FAIL noskip_done got=%b exp=010", {rec_done[1201], rec_done[1202], rec_busy[1202]});
    end
  endtask

  task automatic test_overrun;
    int ones;
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h0D; exp_b[3] = 8'h0A; exp_n = 4;
    launch(0, 80'h00000000000000004142);
    record(425, 50, 80'hFFFF_FFFF_FFFF_FFFF_FFFF);
    tests++;
    if ({rec_ovr[50], rec_ovr[51], rec_ovr[52]} !== 3'b010) begin
      fails++; $display("FAIL ovr_pulse got=%b exp=010", {rec_ovr[50], rec_ovr[51], rec_ovr[52]});
    end
    ones = 0;
    for (int k = 0; k < 425; k++) if (rec_ovr[k] === 1'b1) ones++;
    tests++;
    if (ones !== 1) begin
      fails++; $display("FAIL ovr_count got=%0d exp=1", ones);
    end
    for (int p = 0; p < exp_n * 10 + 1; p++) begin
      logic [9:0] obs, want;
      for (int j = 0; j < 10; j++) begin
        obs[j]  = rec_tx[1 + p * 10 + j];
        want[j] = exp_line(1 + p * 10 + j);
      end
      tests++;
      if (obs !== want) begin
        fails++; $display("FAIL ovr_bit%0d got=%b exp=%b", p, obs, want);
      end
    end
    tests++;
    if (rec_done[402] !== 1'b1) begin
      fails++; $display("FAIL ovr_done got=%b exp=1", rec_done[402]);
    end
  endtask

  task automatic test_all_zero;
    logic [7:0] t, b, d, o;
    launch(2, 80'h0);
    record(8, -1, 80'h0);
    for (int k = 0; k < 8; k++) begin
      t[k] = rec_tx[k]; b[k] = rec_busy[k]; d[k] = rec_done[k]; o[k] = rec_ovr[k];
    end
    tests++;
    if (t !== 8'hFF) begin fails++; $display("FAIL zero_tx got=%b exp=11111111", t); end
    tests++;
    if (b !== 8'b0000_0011) begin fails++; $display("FAIL zero_busy got=%b exp=00000011", b); end
    tests++;
    if (d !== 8'b0000_0100) begin fails++; $display("FAIL zero_done got=%b exp=00000100", d); end
    tests++;
    if (o !== 8'h00) begin fails++; $display("FAIL zero_ovr got=%b exp=00000000", o); end
  endtask

  task automatic test_flag_after_done;
    logic [7:0] b, d, o;
    // Second flag lands in the DONE cycle: overrun, not accepted.
    launch(2, 80'h0);
    record(8, 1, 80'h0);
    for (int k = 0; k < 8; k++) begin b[k] = rec_busy[k]; d[k] = rec_done[k]; o[k] = rec_ovr[k]; end
    tests++;
    if ({b, d, o} !== {8'b0000_0011, 8'b0000_0100, 8'b0000_0100}) begin
      fails++; $display("FAIL flag_in_done got b,d,o=%b_%b_%b exp=00000011_00000100_00000100", b, d, o);
    end
    // Second flag on the first IDLE cycle after DONE: accepted.
    launch(2, 80'h0);
    record(8, 2, 80'h0);
    for (int k = 0; k < 8; k++) begin b[k] = rec_busy[k]; d[k] = rec_done[k]; o[k] = rec_ovr[k]; end
    tests++;
    if (b !== 8'b0001_1011) begin fails++; $display("FAIL flag_after_done_busy got=%b exp=00011011", b); end
    tests++;
    if (d !== 8'b0010_0100) begin fails++; $display("FAIL flag_after_done_done got=%b exp=00100100", d); end
    tests++;
    if (o !== 8'h00) begin fails++; $display("FAIL flag_after_done_ovr got=%b exp=00000000", o); end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    sel    = 0;
    code   = '0;
    flag_r = 1'b0;
    rst_n  = 1'b0;
    test_reset();
    test_skip_zero();
    test_no_skip();
    test_overrun();
    test_all_zero();
    test_flag_after_done();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
